// File: rtl/hwpe_stream_package.sv
// Shared constants for the hwpe-stream blocks.
// The fork's OUT_REG parameter takes one of the two encodings below.
package hwpe_stream_package;

  localparam int unsigned HWPE_STREAM_FORK_PASS = 0;
  localparam int unsigned HWPE_STREAM_FORK_REG  = 1;

endpackage

// File: rtl/hwpe_stream_intf_stream.sv
// Valid/ready stream bundle: the source drives valid, data and strb; the sink drives ready.
// A beat moves on a rising edge where valid and ready are both high. Once raised, valid and data hold until that edge.
interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic [STRB_WIDTH-1:0] strb;

  modport source (output valid, output data, output strb, input ready);
  modport sink   (input valid, input data, input strb, output ready);

endinterface

// File: rtl/hwpe_stream_fork_eager_buf.sv
// One-entry stream buffer with a full flag.
// Can load a new beat in the same cycle that the held beat is popped.
module hwpe_stream_fork_eager_buf #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  push_valid,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic [STRB_WIDTH-1:0] push_strb,
  output logic                  push_ready,
  input  logic                  pop,
  output logic                  full,
  output logic [DATA_WIDTH-1:0] data,
  output logic [STRB_WIDTH-1:0] strb
);

  logic load;

  assign push_ready = ~full | pop;
  assign load       = push_valid & push_ready;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      full <= 1'b0;
      data <= '0;
      strb <= '0;
    end else if (clear_i) begin
      full <= 1'b0;
      data <= '0;
      strb <= '0;
    end else if (load) begin
      full <= 1'b1;
      data <= push_data;
      strb <= push_strb;
    end else if (pop) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/hwpe_stream_fork_eager.sv
// Eager fork: one input stream is broadcast to NB_STREAMS independently consumed lanes.
// The input beat retires only once every lane has accepted it.
module hwpe_stream_fork_eager
  import hwpe_stream_package::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NB_STREAMS = 2,
  parameter int unsigned OUT_REG    = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  test_mode_i,
  hwpe_stream_intf_stream.sink   push_i,
  hwpe_stream_intf_stream.source pop_o [NB_STREAMS]
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  typedef logic [NB_STREAMS-1:0] lane_mask_t;

  lane_mask_t            taken;
  lane_mask_t            hs;
  lane_mask_t            lane_valid;
  lane_mask_t            lane_ready;
  logic                  done;
  logic                  retire;
  logic                  src_valid;
  logic [DATA_WIDTH-1:0] src_data;
  logic [STRB_WIDTH-1:0] src_strb;
  logic                  push_valid;
  logic [DATA_WIDTH-1:0] push_data;
  logic [STRB_WIDTH-1:0] push_strb;
  logic                  unused_test_mode;

  assign unused_test_mode = test_mode_i;
  assign push_valid       = push_i.valid;
  assign push_data        = push_i.data;
  assign push_strb        = push_i.strb;

  for (genvar i = 0; i < NB_STREAMS; i++) begin : gen_lane
    assign pop_o[i].valid = lane_valid[i];
    assign pop_o[i].data  = src_data;
    assign pop_o[i].strb  = src_strb;
    assign lane_ready[i]  = pop_o[i].ready;
  end

  // A lane that already took the beat hides it until every other lane catches up.
  assign lane_valid = {NB_STREAMS{src_valid}} & ~taken;
  assign hs         = lane_valid & lane_ready;
  assign done       = &(taken | hs);
  assign retire     = src_valid & done;

  if (OUT_REG == HWPE_STREAM_FORK_REG) begin : gen_reg
    logic buf_ready;

    hwpe_stream_fork_eager_buf #(
      .DATA_WIDTH (DATA_WIDTH),
      .STRB_WIDTH (STRB_WIDTH)
    ) u_buf (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .clear_i    (clear_i),
      .push_valid (push_valid),
      .push_data  (push_data),
      .push_strb  (push_strb),
      .push_ready (buf_ready),
      .pop        (retire),
      .full       (src_valid),
      .data       (src_data),
      .strb       (src_strb)
    );

    assign push_i.ready = buf_ready;
  end else begin : gen_pass
    assign src_valid    = push_valid;
    assign src_data     = push_data;
    assign src_strb     = push_strb;
    assign push_i.ready = retire;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      taken <= '0;
    end else if (clear_i || retire) begin
      taken <= '0;
    end else begin
      taken <= taken | hs;
    end
  end

`ifndef SYNTHESIS
  // clear_i legitimately drops pending beats, so a stall under clear is exempt.
  assert property (@(posedge clk_i) disable iff (!rst_ni)
    (push_valid && !push_i.ready && !clear_i) |=>
      (push_valid && $stable(push_data) && $stable(push_strb)))
    else $error("push_i valid/data dropped before ready");

  for (genvar i = 0; i < NB_STREAMS; i++) begin : gen_lane_chk
    assert property (@(posedge clk_i) disable iff (!rst_ni)
      (lane_valid[i] && !lane_ready[i] && !clear_i) |=>
        (lane_valid[i] && $stable(src_data)))
      else $error("pop_o[%0d] valid/data dropped before ready", i);
  end

  assert property (@(posedge clk_i) disable iff (!rst_ni)
    ($bits(push_i.data) == DATA_WIDTH) &&
    (OUT_REG == HWPE_STREAM_FORK_PASS || OUT_REG == HWPE_STREAM_FORK_REG))
    else $error("interface width or OUT_REG encoding mismatch");
`endif

endmodule

// File: tb/tb_hwpe_stream_fork_eager.sv
// Directed bench for the eager fork: one pass-through instance and one registered instance.
module tb_hwpe_stream_fork_eager;

  localparam int unsigned DW = 16;
  localparam int unsigned NB = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic clr0;
  logic clr1;
  logic test_mode;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) p0 ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) q0 [NB] ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) p1 ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) q1 [NB] ();

  hwpe_stream_fork_eager #(
    .DATA_WIDTH (DW),
    .NB_STREAMS (NB),
    .OUT_REG    (0)
  ) u_pass (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .clear_i     (clr0),
    .test_mode_i (test_mode),
    .push_i      (p0),
    .pop_o       (q0)
  );

  hwpe_stream_fork_eager #(
    .DATA_WIDTH (DW),
    .NB_STREAMS (NB),
    .OUT_REG    (1)
  ) u_reg (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .clear_i     (clr1),
    .test_mode_i (test_mode),
    .push_i      (p1),
    .pop_o       (q1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    clr0        = 1'b0;
    clr1        = 1'b0;
    test_mode   = 1'b0;
    p0.valid    = 1'b0;
    p0.data     = '0;
    p0.strb     = '0;
    p1.valid    = 1'b0;
    p1.data     = '0;
    p1.strb     = '0;
    q0[0].ready = 1'b0;
    q0[1].ready = 1'b0;
    q1[0].ready = 1'b0;
    q1[1].ready = 1'b0;
    #3;

    // reset values
    chk("rst_pass_v0", q0[0].valid, 1'b0);
    chk("rst_pass_v1", q0[1].valid, 1'b0);
    chk("rst_pass_ready", p0.ready, 1'b0);
    chk("rst_reg_v0", q1[0].valid, 1'b0);
    chk("rst_reg_v1", q1[1].valid, 1'b0);
    chk("rst_reg_ready", p1.ready, 1'b1);
    chk("rst_reg_data", q1[0].data, 16'h0000);
    chk("rst_reg_strb", q1[1].strb, 2'b00);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // pass-through, both lanes ready
    p0.valid = 1'b1; p0.data = 16'hA5A5; p0.strb = 2'b11;
    q0[0].ready = 1'b1; q0[1].ready = 1'b1;
    #1;
    chk("t1_v0", q0[0].valid, 1'b1);
    chk("t1_v1", q0[1].valid, 1'b1);
    chk("t1_d0", q0[0].data, 16'hA5A5);
    chk("t1_d1", q0[1].data, 16'hA5A5);
    chk("t1_s1", q0[1].strb, 2'b11);
    chk("t1_ready", p0.ready, 1'b1);
    tick();

    // pass-through, lane1 stalled for three cycles
    p0.data = 16'h1234; q0[1].ready = 1'b0;
    #1;
    chk("t2_c1_v0", q0[0].valid, 1'b1);
    chk("t2_c1_v1", q0[1].valid, 1'b1);
    chk("t2_c1_d0", q0[0].data, 16'h1234);
    chk("t2_c1_ready", p0.ready, 1'b0);
    tick();
    #1;
    chk("t2_c2_v0", q0[0].valid, 1'b0);
    chk("t2_c2_v1", q0[1].valid, 1'b1);
    chk("t2_c2_ready", p0.ready, 1'b0);
    tick();
    #1;
    chk("t2_c3_v0", q0[0].valid, 1'b0);
    chk("t2_c3_ready", p0.ready, 1'b0);
    tick();
    q0[1].ready = 1'b1;
    #1;
    chk("t2_c4_v0", q0[0].valid, 1'b0);
    chk("t2_c4_v1", q0[1].valid, 1'b1);
    chk("t2_c4_d1", q0[1].data, 16'h1234);
    chk("t2_c4_ready", p0.ready, 1'b1);
    tick();
    p0.data = 16'h5678;
    #1;
    chk("t2_c5_v0", q0[0].valid, 1'b1);
    chk("t2_c5_v1", q0[1].valid, 1'b1);
    chk("t2_c5_ready", p0.ready, 1'b1);
    tick();
    p0.valid = 1'b0; q0[0].ready = 1'b0; q0[1].ready = 1'b0;

    // registered, back-to-back stream with both lanes ready
    q1[0].ready = 1'b1; q1[1].ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      p1.valid = 1'b1; p1.data = 16'(k + 1); p1.strb = 2'b11;
      #1;
      chk("t3_ready", p1.ready, 1'b1);
      if (k == 0) begin
        chk("t3_first_v0", q1[0].valid, 1'b0);
        chk("t3_first_v1", q1[1].valid, 1'b0);
      end else begin
        chk("t3_v0", q1[0].valid, 1'b1);
        chk("t3_v1", q1[1].valid, 1'b1);
        chk("t3_d0", q1[0].data, 32'(k));
        chk("t3_d1", q1[1].data, 32'(k));
      end
      tick();
    end
    p1.valid = 1'b0;
    #1;
    chk("t3_last_v0", q1[0].valid, 1'b1);
    chk("t3_last_d1", q1[1].data, 16'h0008);
    chk("t3_last_s0", q1[0].strb, 2'b11);
    tick();
    #1;
    chk("t3_idle_v0", q1[0].valid, 1'b0);
    chk("t3_idle_v1", q1[1].valid, 1'b0);

    // registered, lane1 stalled; next beat waits for the retire cycle
    q1[1].ready = 1'b0;
    p1.valid = 1'b1; p1.data = 16'hBEEF;
    #1;
    chk("t4_a_ready", p1.ready, 1'b1);
    tick();
    p1.data = 16'hCAFE;
    #1;
    chk("t4_b_v0", q1[0].valid, 1'b1);
    chk("t4_b_d0", q1[0].data, 16'hBEEF);
    chk("t4_b_v1", q1[1].valid, 1'b1);
    chk("t4_b_ready", p1.ready, 1'b0);
    tick();
    #1;
    chk("t4_c_v0", q1[0].valid, 1'b0);
    chk("t4_c_v1", q1[1].valid, 1'b1);
    chk("t4_c_ready", p1.ready, 1'b0);
    tick();
    q1[1].ready = 1'b1;
    #1;
    chk("t4_d_d1", q1[1].data, 16'hBEEF);
    chk("t4_d_ready", p1.ready, 1'b1);
    tick();
    p1.valid = 1'b0;
    #1;
    chk("t4_e_v0", q1[0].valid, 1'b1);
    chk("t4_e_v1", q1[1].valid, 1'b1);
    chk("t4_e_d0", q1[0].data, 16'hCAFE);
    chk("t4_e_d1", q1[1].data, 16'hCAFE);
    tick();
    #1;
    chk("t4_f_v0", q1[0].valid, 1'b0);
    chk("t4_f_ready", p1.ready, 1'b1);

    // clear while lane0 has taken and the buffer is full
    q1[1].ready = 1'b0;
    p1.valid = 1'b1; p1.data = 16'hBEEF;
    #1;
    tick();
    p1.valid = 1'b0;
    tick();
    clr1 = 1'b1;
    #1;
    chk("t5_pre_v0", q1[0].valid, 1'b0);
    chk("t5_pre_v1", q1[1].valid, 1'b1);
    chk("t5_pre_ready", p1.ready, 1'b0);
    tick();
    clr1 = 1'b0;
    q1[1].ready = 1'b1;
    #1;
    chk("t5_post_v0", q1[0].valid, 1'b0);
    chk("t5_post_v1", q1[1].valid, 1'b0);
    chk("t5_post_ready", p1.ready, 1'b1);
    tick();
    #1;
    chk("t5_never_v1", q1[1].valid, 1'b0);

    // async reset between edges
    q1[0].ready = 1'b0; q1[1].ready = 1'b0;
    p1.valid = 1'b1; p1.data = 16'h7777; p1.strb = 2'b01;
    #1;
    tick();
    p1.valid = 1'b0;
    #1;
    chk("t6_pre_v0", q1[0].valid, 1'b1);
    chk("t6_pre_d0", q1[0].data, 16'h7777);
    chk("t6_pre_ready", p1.ready, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_v0", q1[0].valid, 1'b0);
    chk("t6_rst_v1", q1[1].valid, 1'b0);
    chk("t6_rst_d0", q1[0].data, 16'h0000);
    chk("t6_rst_s1", q1[1].strb, 2'b00);
    chk("t6_rst_ready", p1.ready, 1'b1);
    chk("t6_rst_pass_ready", p0.ready, 1'b0);
    #3;
    rst_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
